// File: rtl/sr_pkg.sv
// Shared definitions for the sr shift-register family.
package sr_pkg;

   typedef enum logic {
      SHIFT_LEFT  = 1'b0,
      SHIFT_RIGHT = 1'b1
   } SHIFT_OP;

endpackage

// File: rtl/sr_serializer_if.sv
// Load (word) and serial (bit) handshake bundle for sr_serializer.
interface sr_serializer_if
   import sr_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) ();

   SHIFT_OP            op;
   logic               load_valid;
   logic [WIDTH-1:0]   load_data;
   logic               load_ready;
   logic               serial_out;
   logic               serial_valid;
   logic               serial_last;
   logic               serial_ready;

   modport master (
      output op, load_valid, load_data, serial_ready,
      input  load_ready, serial_out, serial_valid, serial_last
   );

   modport slave (
      input  op, load_valid, load_data, serial_ready,
      output load_ready, serial_out, serial_valid, serial_last
   );

endinterface

// File: rtl/sr_serializer.sv
// Parallel-in, serial-out transmitter; bit order per word chosen by op so that an
// sr receiver with the same op reassembles the word.
module sr_serializer
   import sr_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input logic            clk,
   input logic            reset,
   sr_serializer_if.slave bus
);

   localparam int unsigned CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("sr_serializer: WIDTH must be >= 2");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      SHIFT
   } SER_STATE;

   SER_STATE         state;
   logic [WIDTH-1:0] shreg;
   SHIFT_OP          op_q;
   logic [CNT_W-1:0] cnt;

   logic load_acc;
   logic bit_acc;
   logic is_last;

   assign is_last = (state == SHIFT) && (cnt == LAST_CNT);
   assign bit_acc = (state == SHIFT) && bus.serial_ready;
   assign load_acc = bus.load_valid && bus.load_ready;

   assign bus.serial_valid = (state == SHIFT);
   assign bus.serial_last  = is_last;
   assign bus.serial_out   = (state == SHIFT) &&
                             ((op_q == SHIFT_LEFT) ? shreg[WIDTH-1] : shreg[0]);
   // Ready on the last-bit accept lets the next word start with no bubble.
   assign bus.load_ready   = reset && ((state == IDLE) || (is_last && bus.serial_ready));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         shreg <= '0;
         op_q  <= SHIFT_LEFT;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_acc) begin
                  shreg <= bus.load_data;
                  op_q  <= bus.op;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_acc) begin
                  if (is_last) begin
                     if (load_acc) begin
                        shreg <= bus.load_data;
                        op_q  <= bus.op;
                        cnt   <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                     if (op_q == SHIFT_LEFT) begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                     end else begin
                        shreg <= {1'b0, shreg[WIDTH-1:1]};
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sr_serializer.md
# sr_serializer

Parallel-in, serial-out transmitter, the counterpart of the team's serial-in shift register. It accepts a WIDTH-bit word over a valid/ready load handshake and emits it one bit per accepted beat on a valid/ready serial interface. Bit order is selected per word by `SHIFT_OP`, so that a `sr` receiver clocked with the same `op` reassembles the original word. It sits between word-level producers and the serial link.

## Interface

**Parameters**
- `WIDTH`, default 4: word width in bits. Must be ≥ 2; elaboration fails otherwise.

**Ports**
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `op`  in  `SHIFT_OP`  bit order; sampled only when a load is accepted
- `load_valid`  in  1  producer has a word on `load_data`
- `load_data`  in  WIDTH  word to serialize
- `load_ready`  out  1  block can accept a word this cycle
- `serial_out`  out  1  current bit
- `serial_valid`  out  1  `serial_out` is valid
- `serial_last`  out  1  current bit is the final bit of the word
- `serial_ready`  in  1  consumer accepts the current bit

## Operation

- **Storage:** word register `shreg[WIDTH-1:0]`, latched `op_q`, bit counter `cnt` of width `$clog2(WIDTH)`.
- **States:** `IDLE`, `SHIFT`.
- **Load accept:** a load is accepted when `load_valid && load_ready`.
- **Serial accept:** a bit is accepted when `serial_valid && serial_ready`.
- **IDLE:**
  - Outputs: `load_ready=1`, `serial_valid=0`, `serial_last=0`, `serial_out=0`.
  - On load accept: `shreg<=load_data`, `op_q<=op`, `cnt<=0`, go to SHIFT.
- **SHIFT:**
  - Outputs: `serial_valid=1`.
  - If `op_q==SHIFT_LEFT`, `serial_out=shreg[WIDTH-1]` (MSB first).
  - If `op_q==SHIFT_RIGHT`, `serial_out=shreg[0]` (LSB first).
  - `serial_last = (cnt==WIDTH-1)`.
- **Serial accept, not last bit:** `cnt<=cnt+1`.
  - SHIFT_LEFT: `shreg<={shreg[WIDTH-2:0],1'b0}`.
  - SHIFT_RIGHT: `shreg<={1'b0,shreg[WIDTH-1:1]}`.
- **Serial accept, last bit:**
  - If `load_valid` is high the same cycle, load the new word (as in IDLE) and stay in SHIFT.
  - Otherwise go to IDLE.
- **load_ready:** `load_ready = reset && (state==IDLE || (serial_last && serial_ready))`. This is the only combinational ready path and it gives back-to-back throughput.
- **Backpressure:** while `serial_ready=0`, `serial_out`, `serial_last`, `shreg` and `cnt` hold. `serial_valid` never drops mid-word.
- **Input stability:** `op` and `load_data` are ignored except on a load accept. Changing `op` mid-word has no effect.
- **Reset:** `reset=0` at a clock edge forces IDLE and clears `shreg`, `op_q` and `cnt`. This aborts any word in flight, with no `serial_last` emitted. While `reset=0`, `load_ready=0`.

## Timing

- **Reset values:** `load_ready=0` (while in reset), `serial_valid=0`, `serial_last=0`, `serial_out=0`. `load_ready=1` in the first cycle after reset release.
- **Load latency:** load accepted at edge N → first bit valid after edge N (cycle N+1).
- **Word duration:** with `serial_ready` held high, bits are presented in cycles N+1 … N+WIDTH. `serial_last` is high in cycle N+WIDTH only.
- **Back-to-back:** a load coinciding with the last-bit accept produces the next word's first bit in the following cycle, with zero bubbles. Sustained throughput is 1 bit/cycle.
- **Idle gap:** without a coinciding load, `serial_valid` is low in the cycle after the last bit.

## Structure

- **Shared package `sr_pkg`:** move the `SHIFT_OP` typedef here; both `sr` and `sr_serializer` import it.
- **State enum:** the `SER_STATE` enum (`IDLE`, `SHIFT`) is local to this module.
- **Sub-modules:** none required; shifting and counting are inline in a single module.

## Test plan

- **Reset:** hold `reset=0` 3 cycles with `load_valid=1` → `load_ready=0`, `serial_valid=0`, `serial_out=0` throughout. Release → `load_ready=1`.
- **MSB first:** WIDTH=4, `op=SHIFT_LEFT`, load 4'b1011, `serial_ready=1` → `serial_out` 1,0,1,1 in cycles N+1..N+4. `serial_last` only at N+4. `serial_valid=0` at N+5.
- **LSB first:** `op=SHIFT_RIGHT`, load 4'b1011 → `serial_out` 1,1,0,1. Toggle `op` mid-word → sequence unchanged.
- **Backpressure:** load 4'b0110 with SHIFT_LEFT. Drop `serial_ready` for 3 cycles after the first bit → second bit (1) held stable, `cnt` frozen. Word completes 3 cycles later; total 7 valid cycles.
- **Back-to-back and reset abort:**
  - Load 4'hA, then 4'h5 offered on the last beat → eight consecutive valid bits 1010_0101 (SHIFT_LEFT), no gap.
  - Separately, assert reset after bit 2 → next cycle `serial_valid=0`, no `serial_last`.
- **Loopback:** connect to `sr` (same WIDTH and op, `shift_in=serial_out`, enabled on serial accept) for 200 random words and both ops → `sr.shift_out` equals the loaded word after each `serial_last`.
